cnt_seq_ctrl: RTL and testbench



---
 rtl/cnt_seq_pkg.sv | 50 +++++
 rtl/cnt_tick_gen.sv | 36 +++
 rtl/cnt_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// rtl/cnt_seq_pkg.sv - shared types, constants and step function for the counter sequencer
//
// Contents:
//   state_t    : sequencer states IDLE/RUN/PAUSE/DONE (2-bit encoding)
//   BCD_MAX    : terminal value when the BCD option is built in
//   step_t     : next count value plus wrap flag
//   next_count : one up/down step of a counter bounded by max
package cnt_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned BCD_MAX = 9;

   typedef struct packed {
      logic        wrap;
      logic [31:0] val;
   } step_t;

   // Values above max (not reachable in normal use) are treated as terminal
   // so an up step always lands back in range.
   function automatic step_t next_count(input logic [31:0] cur,
                                        input logic        up,
                                        input logic [31:0] max);
      step_t r;
      if (up) begin
         if (cur >= max) begin
            r.val  = '0;
            r.wrap = 1'b1;
         end else begin
            r.val  = cur + 32'd1;
            r.wrap = 1'b0;
         end
      end else begin
         if (cur == '0) begin
            r.val  = max;
            r.wrap = 1'b1;
         end else begin
            r.val  = cur - 32'd1;
            r.wrap = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cnt_tick_gen.sv
// rtl/cnt_tick_gen.sv - prescaler producing the count-step request
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   en       : advance the prescaler this cycle; value is held while low
//   clr      : force the prescaler to zero (wins over en)
//   step_due : prescaler sits at TICK_DIV-1, so an enabled edge is a step edge
module cnt_tick_gen #(
   parameter int TICK_DIV = 62500000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step_due
);

   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

   logic [DW-1:0] div_cnt;

   assign step_due = (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= step_due ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - run/pause/load sequencer around a prescaled up/down counter
//
// Optional build macro CNT_SEQ_BCD_EN: count modulo 10 in the low nibble,
// upper bits held at 0, loads clamped to 9.
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   start    : begin/resume counting (level)
//   stop     : pause from RUN, abort from PAUSE (level)
//   load     : parallel load strobe, highest priority
//   load_val : value written on load
//   dir_up   : 1 = up, 0 = down, sampled at each step
//   one_shot : 1 = stop in DONE at terminal count, 0 = wrap and continue
//   cnt      : current count
//   tick     : one-cycle pulse after each step
//   tc       : one-cycle pulse after a wrapping step
//   busy     : state is RUN
//   done     : state is DONE
module cnt_seq_ctrl
   import cnt_seq_pkg::*;
#(
   parameter int TICK_DIV = 62500000,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dir_up,
   input  logic             one_shot,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             tc,
   output logic             busy,
   output logic             done
);

`ifdef CNT_SEQ_BCD_EN
   localparam logic [31:0] CNT_MAX = 32'(BCD_MAX);
`else
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
`endif

   state_t           state;
   logic             step_due;
   logic             tg_en;
   logic             tg_clr;
   step_t            nxt;
   logic [CNT_W-1:0] load_cnt;
   logic             unused_nxt;

   // Prescaler only runs in RUN when neither load nor stop overrides the
   // edge; stop therefore leaves a due step pending for the resume edge.
   assign tg_en  = (state == RUN) && !stop && !load;
   assign tg_clr = load || (start && !stop && ((state == IDLE) || (state == DONE)));

   cnt_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (tg_en),
      .clr      (tg_clr),
      .step_due (step_due)
   );

   assign nxt        = next_count(32'(cnt), dir_up, CNT_MAX);
   assign unused_nxt = ^nxt.val;

`ifdef CNT_SEQ_BCD_EN
   logic unused_load_hi;
   assign unused_load_hi = ^load_val;
   always_comb begin
      load_cnt      = '0;
      load_cnt[3:0] = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
   end
`else
   assign load_cnt = load_val;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         tick  <= 1'b0;
         tc    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         tick <= 1'b0;
         tc   <= 1'b0;
         if (load) begin
            cnt <= load_cnt;
            if (state == DONE) begin
               state <= IDLE;
               done  <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start && !stop) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
               RUN: begin
                  if (stop) begin
                     state <= PAUSE;
                     busy  <= 1'b0;
                  end else if (step_due) begin
                     cnt  <= nxt.val[CNT_W-1:0];
                     tick <= 1'b1;
                     tc   <= nxt.wrap;
                     if (nxt.wrap && one_shot) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
               PAUSE: begin
                  if (stop) begin
                     state <= IDLE;
                  end else if (start) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
               DONE: begin
                  if (start && !stop) begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - directed self-checking bench for cnt_seq_ctrl
module tb_cnt_seq_ctrl;

`ifdef CNT_SEQ_BCD_EN
   localparam int MAXV     = 9;
   localparam int LD_EXP   = 9;
   localparam int LD_NEXT  = 0;
   localparam int LD_NTC   = 1;
`else
   localparam int MAXV     = 15;
   localparam int LD_EXP   = 12;
   localparam int LD_NEXT  = 13;
   localparam int LD_NTC   = 0;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       load;
   logic [3:0] load_val;
   logic       dir_up;
   logic       one_shot;
   logic [3:0] cnt;
   logic       tick;
   logic       tc;
   logic       busy;
   logic       done;

   int n_cmp;
   int n_err;

   cnt_seq_ctrl #(
      .TICK_DIV (4),
      .CNT_W    (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .load     (load),
      .load_val (load_val),
      .dir_up   (dir_up),
      .one_shot (one_shot),
      .cnt      (cnt),
      .tick     (tick),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go_idle(input logic [3:0] v);
      stop = 1'b1;
      clk_n(2);
      stop = 1'b0;
      load_val = v;
      load = 1'b1;
      clk_n(1);
      load = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
      load_val = 4'd0; dir_up = 1'b1; one_shot = 1'b0;
      clk_n(2);
      n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
      n_cmp++; if ({tick, tc, busy, done} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {tick, tc, busy, done}); end
      rst = 1'b1;
      clk_n(1);
   endtask

   task automatic test_free_run_up;
      go_idle(4'd0);
      dir_up = 1'b1; one_shot = 1'b0;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fr_busy got=%b exp=1", busy); end
      for (int s = 1; s <= MAXV + 1; s++) begin
         for (int q = 0; q < 3; q++) begin
            clk_n(1);
            n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL fr_idle_tick step=%0d got=%b exp=0", s, tick); end
         end
         clk_n(1);
         n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL fr_tick step=%0d got=%b exp=1", s, tick); end
         n_cmp++; if (cnt !== 4'(s % (MAXV + 1))) begin n_err++; $display("FAIL fr_cnt step=%0d got=%0d exp=%0d", s, cnt, s % (MAXV + 1)); end
         n_cmp++; if (tc !== (s == MAXV + 1)) begin n_err++; $display("FAIL fr_tc step=%0d got=%b exp=%b", s, tc, (s == MAXV + 1)); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fr_busy_run step=%0d got=%b exp=1", s, busy); end
      end
   endtask

   task automatic test_one_shot_down;
      int exp_c [4];
      exp_c = '{2, 1, 0, MAXV};
      go_idle(4'd3);
      dir_up = 1'b0; one_shot = 1'b1;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      for (int s = 0; s < 4; s++) begin
         clk_n(4);
         n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL os_tick step=%0d got=%b exp=1", s, tick); end
         n_cmp++; if (cnt !== 4'(exp_c[s])) begin n_err++; $display("FAIL os_cnt step=%0d got=%0d exp=%0d", s, cnt, exp_c[s]); end
         n_cmp++; if (tc !== (s == 3)) begin n_err++; $display("FAIL os_tc step=%0d got=%b exp=%b", s, tc, (s == 3)); end
      end
      n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL os_done got busy/done=%b exp=01", {busy, done}); end
      for (int q = 0; q < 10; q++) begin
         clk_n(1);
         n_cmp++; if (tick !== 1'b0 || cnt !== 4'(MAXV)) begin n_err++; $display("FAIL os_halt cyc=%0d tick=%b cnt=%0d exp tick=0 cnt=%0d", q, tick, cnt, MAXV); end
      end
      load_val = 4'd5; load = 1'b1;
      clk_n(1);
      load = 1'b0;
      n_cmp++; if ({busy, done, cnt} !== {2'b00, 4'd5}) begin n_err++; $display("FAIL os_load_idle got busy/done=%b cnt=%0d exp 00 5", {busy, done}, cnt); end
   endtask

   task automatic test_stop_on_due;
      go_idle(4'd4);
      dir_up = 1'b1; one_shot = 1'b0;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      clk_n(4);
      n_cmp++; if (cnt !== 4'd5) begin n_err++; $display("FAIL sd_pre got=%0d exp=5", cnt); end
      clk_n(3);
      stop = 1'b1;
      clk_n(1);
      stop = 1'b0;
      n_cmp++; if ({cnt, tick, busy} !== {4'd5, 1'b0, 1'b0}) begin n_err++; $display("FAIL sd_pause cnt=%0d tick=%b busy=%b exp 5 0 0", cnt, tick, busy); end
      clk_n(3);
      n_cmp++; if (cnt !== 4'd5) begin n_err++; $display("FAIL sd_hold got=%0d exp=5", cnt); end
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      n_cmp++; if ({cnt, tick, busy} !== {4'd5, 1'b0, 1'b1}) begin n_err++; $display("FAIL sd_resume cnt=%0d tick=%b busy=%b exp 5 0 1", cnt, tick, busy); end
      clk_n(1);
      n_cmp++; if ({cnt, tick} !== {4'd6, 1'b1}) begin n_err++; $display("FAIL sd_step cnt=%0d tick=%b exp 6 1", cnt, tick); end
   endtask

   task automatic test_load_on_due;
      go_idle(4'd6);
      dir_up = 1'b1; one_shot = 1'b0;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      clk_n(4);
      n_cmp++; if (cnt !== 4'd7) begin n_err++; $display("FAIL ld_pre got=%0d exp=7", cnt); end
      clk_n(3);
      load_val = 4'd12; load = 1'b1;
      clk_n(1);
      load = 1'b0;
      n_cmp++; if ({cnt, tick, tc, busy} !== {4'(LD_EXP), 3'b001}) begin n_err++; $display("FAIL ld_load cnt=%0d tick=%b tc=%b busy=%b exp %0d 0 0 1", cnt, tick, tc, busy, LD_EXP); end
      for (int q = 0; q < 3; q++) begin
         clk_n(1);
         n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL ld_wait cyc=%0d got=%b exp=0", q, tick); end
      end
      clk_n(1);
      n_cmp++; if ({cnt, tick, tc} !== {4'(LD_NEXT), 1'b1, 1'(LD_NTC)}) begin n_err++; $display("FAIL ld_next cnt=%0d tick=%b tc=%b exp %0d 1 %0d", cnt, tick, tc, LD_NEXT, LD_NTC); end
   endtask

   task automatic test_reset_mid_run;
      go_idle(4'd8);
      dir_up = 1'b1; one_shot = 1'b0;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      clk_n(4);
      n_cmp++; if ({cnt, tick} !== {4'd9, 1'b1}) begin n_err++; $display("FAIL rm_pre cnt=%0d tick=%b exp 9 1", cnt, tick); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if ({cnt, tick, tc, busy, done} !== 8'h00) begin n_err++; $display("FAIL rm_async cnt=%0d flags=%b exp 0 0000", cnt, {tick, tc, busy, done}); end
      #2;
      rst = 1'b1;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy got=%b exp=1", busy); end
      clk_n(3);
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rm_early got=%b exp=0", tick); end
      clk_n(1);
      n_cmp++; if ({cnt, tick} !== {4'd1, 1'b1}) begin n_err++; $display("FAIL rm_first cnt=%0d tick=%b exp 1 1", cnt, tick); end
   endtask

`ifdef CNT_SEQ_BCD_EN
   task automatic test_bcd;
      go_idle(4'd8);
      dir_up = 1'b1; one_shot = 1'b0;
      start = 1'b1;
      clk_n(1);
      start = 1'b0;
      clk_n(4);
      n_cmp++; if ({cnt, tc} !== {4'd9, 1'b0}) begin n_err++; $display("FAIL bcd_9 cnt=%0d tc=%b exp 9 0", cnt, tc); end
      clk_n(4);
      n_cmp++; if ({cnt, tc} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL bcd_wrap cnt=%0d tc=%b exp 0 1", cnt, tc); end
      load_val = 4'd14; load = 1'b1;
      clk_n(1);
      load = 1'b0;
      n_cmp++; if (cnt !== 4'd9) begin n_err++; $display("FAIL bcd_clamp got=%0d exp=9", cnt); end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_free_run_up();
      test_one_shot_down();
      test_stop_on_due();
      test_load_on_due();
      test_reset_mid_run();
`ifdef CNT_SEQ_BCD_EN
      test_bcd();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
